// File: rtl/uart_rx_fifo_ctrl.sv
// rtl/uart_rx_fifo_ctrl.sv - UART receive FIFO controller with level flags, overrun and timeout
// Buffers received characters with their error bits; the DSP drains them through a show-ahead head register.
module uart_rx_fifo_ctrl #(
  parameter int          DEPTH       = 16,
  parameter logic [15:0] TIMEOUT_CYC = 16'd4000
) (
  input  logic       DSP_CLK,
  input  logic       RESET,
  input  logic       DSP_CEn,
  input  logic       DSP_REn,
  output logic [7:0] DSP_RDATA,
  input  logic       RxFIFO_En,
  input  logic       RxFIFO_Clr,
  input  logic [1:0] RxTrigLvl,
  input  logic       RxOvrClr,
  input  logic       RxDataValid,
  input  logic [7:0] RxData,
  input  logic       RxParityErr,
  input  logic       RxFrameErr,
  output logic       RxHeadParityErr,
  output logic       RxHeadFrameErr,
  output logic       RxFIFO_Empty,
  output logic       RxFIFO_Full,
  output logic       RxFIFO_L14_Full,
  output logic       RxFIFO_L12_Full,
  output logic       RxFIFO_L8_Full,
  output logic       RxFIFO_L4_Full,
  output logic       RxFIFO_L2_Full,
  output logic       RxTrigger,
  output logic       RxOverrun,
  output logic       RxErrInFIFO,
  output logic       RxTimeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [9:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] err_cnt;
  logic [15:0]   idle;
  logic          rd_strb_q;
  logic          en_q;
  logic          overrun_q;

  logic [CW-1:0] cap;
  logic [31:0]   count_w;
  logic [31:0]   trig_lvl;
  logic [9:0]    head;
  logic          rd_strb;
  logic          rd_edge;
  logic          empty;
  logic          full;
  logic          flush;
  logic          do_push;
  logic          do_pop;
  logic          lost;
  logic          push_err;
  logic          pop_err;

  always_comb begin
    cap      = RxFIFO_En ? CW'(DEPTH) : CW'(1);
    count_w  = 32'(count);
    head     = mem[rd_ptr];
    rd_strb  = !DSP_CEn && !DSP_REn;
    rd_edge  = rd_strb && !rd_strb_q;
    empty    = (count == '0);
    full     = (count == cap);
    // Changing the FIFO mode invalidates the stored layout, so it flushes like RxFIFO_Clr.
    flush    = RxFIFO_Clr || (RxFIFO_En != en_q);
    do_pop   = rd_edge && !empty && !flush;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the character.
    do_push  = RxDataValid && !flush && (!full || do_pop);
    lost     = RxDataValid && !flush && full && !do_pop;
    push_err = RxParityErr || RxFrameErr;
    pop_err  = head[9] || head[8];
  end

  always_ff @(posedge DSP_CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= {RxFrameErr, RxParityErr, RxData};
    end
  end

  always_ff @(posedge DSP_CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_cnt   <= '0;
      rd_strb_q <= 1'b0;
      en_q      <= 1'b0;
    end else begin
      rd_strb_q <= rd_strb;
      en_q      <= RxFIFO_En;
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count   <= '0;
        err_cnt <= '0;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + AW'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
        if (do_push && !do_pop) begin
          count <= count + CW'(1);
        end else if (do_pop && !do_push) begin
          count <= count - CW'(1);
        end
        if ((do_push && push_err) && !(do_pop && pop_err)) begin
          err_cnt <= err_cnt + CW'(1);
        end else if ((do_pop && pop_err) && !(do_push && push_err)) begin
          err_cnt <= err_cnt - CW'(1);
        end
      end
    end
  end

  always_ff @(posedge DSP_CLK or posedge RESET) begin
    if (RESET) begin
      overrun_q <= 1'b0;
    end else if (lost) begin
      overrun_q <= 1'b1;
    end else if (RxOvrClr) begin
      overrun_q <= 1'b0;
    end
  end

  // Idle time is measured only while characters sit unread in the FIFO.
  always_ff @(posedge DSP_CLK or posedge RESET) begin
    if (RESET) begin
      idle <= '0;
    end else if (do_push || do_pop || flush || empty) begin
      idle <= '0;
    end else if (idle != TIMEOUT_CYC) begin
      idle <= idle + 16'd1;
    end
  end

  always_comb begin
    case (RxTrigLvl)
      2'b00:   trig_lvl = 32'd1;
      2'b01:   trig_lvl = 32'd4;
      2'b10:   trig_lvl = 32'd8;
      default: trig_lvl = 32'd14;
    endcase
  end

  always_comb begin
    DSP_RDATA       = empty ? 8'h00 : head[7:0];
    RxHeadParityErr = !empty && head[8];
    RxHeadFrameErr  = !empty && head[9];
    RxFIFO_Empty    = empty;
    RxFIFO_Full     = full;
    RxFIFO_L14_Full = (count_w >= 32'd14);
    RxFIFO_L12_Full = (count_w >= 32'd12);
    RxFIFO_L8_Full  = (count_w >= 32'd8);
    RxFIFO_L4_Full  = (count_w >= 32'd4);
    RxFIFO_L2_Full  = (count_w >= 32'd2);
    RxTrigger       = (count_w >= trig_lvl);
    RxOverrun       = overrun_q;
    RxErrInFIFO     = (err_cnt != '0);
    RxTimeout       = (idle == TIMEOUT_CYC) && !empty;
  end

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// tb/tb_uart_rx_fifo_ctrl.sv - directed self-checking bench for uart_rx_fifo_ctrl
// Hand-computed expectations for ordering, overrun, holding mode, strobes, errors and timeout.
module tb_uart_rx_fifo_ctrl;

  logic       DSP_CLK = 1'b0;
  logic       RESET;
  logic       DSP_CEn;
  logic       DSP_REn;
  logic [7:0] DSP_RDATA;
  logic       RxFIFO_En;
  logic       RxFIFO_Clr;
  logic [1:0] RxTrigLvl;
  logic       RxOvrClr;
  logic       RxDataValid;
  logic [7:0] RxData;
  logic       RxParityErr;
  logic       RxFrameErr;
  logic       RxHeadParityErr;
  logic       RxHeadFrameErr;
  logic       RxFIFO_Empty;
  logic       RxFIFO_Full;
  logic       RxFIFO_L14_Full;
  logic       RxFIFO_L12_Full;
  logic       RxFIFO_L8_Full;
  logic       RxFIFO_L4_Full;
  logic       RxFIFO_L2_Full;
  logic       RxTrigger;
  logic       RxOverrun;
  logic       RxErrInFIFO;
  logic       RxTimeout;

  int checks = 0;
  int errors = 0;
  logic [7:0] d;

  always #5 DSP_CLK = ~DSP_CLK;

  uart_rx_fifo_ctrl #(.DEPTH(16), .TIMEOUT_CYC(16'd20)) dut (
    .DSP_CLK(DSP_CLK), .RESET(RESET), .DSP_CEn(DSP_CEn), .DSP_REn(DSP_REn),
    .DSP_RDATA(DSP_RDATA), .RxFIFO_En(RxFIFO_En), .RxFIFO_Clr(RxFIFO_Clr),
    .RxTrigLvl(RxTrigLvl), .RxOvrClr(RxOvrClr), .RxDataValid(RxDataValid),
    .RxData(RxData), .RxParityErr(RxParityErr), .RxFrameErr(RxFrameErr),
    .RxHeadParityErr(RxHeadParityErr), .RxHeadFrameErr(RxHeadFrameErr),
    .RxFIFO_Empty(RxFIFO_Empty), .RxFIFO_Full(RxFIFO_Full),
    .RxFIFO_L14_Full(RxFIFO_L14_Full), .RxFIFO_L12_Full(RxFIFO_L12_Full),
    .RxFIFO_L8_Full(RxFIFO_L8_Full), .RxFIFO_L4_Full(RxFIFO_L4_Full),
    .RxFIFO_L2_Full(RxFIFO_L2_Full), .RxTrigger(RxTrigger), .RxOverrun(RxOverrun),
    .RxErrInFIFO(RxErrInFIFO), .RxTimeout(RxTimeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge DSP_CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] v, input logic pe, input logic fe);
    RxDataValid = 1'b1;
    RxData      = v;
    RxParityErr = pe;
    RxFrameErr  = fe;
    tick();
    RxDataValid = 1'b0;
    RxParityErr = 1'b0;
    RxFrameErr  = 1'b0;
  endtask

  task automatic read_byte(output logic [7:0] v);
    v       = DSP_RDATA;
    DSP_CEn = 1'b0;
    DSP_REn = 1'b0;
    tick();
    DSP_CEn = 1'b1;
    DSP_REn = 1'b1;
    tick();
  endtask

  task automatic pulse_ovr_clr();
    RxOvrClr = 1'b1;
    tick();
    RxOvrClr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1; DSP_CEn = 1'b1; DSP_REn = 1'b1; RxFIFO_En = 1'b1; RxFIFO_Clr = 1'b0;
    RxTrigLvl = 2'b00; RxOvrClr = 1'b0; RxDataValid = 1'b0; RxData = 8'h00;
    RxParityErr = 1'b0; RxFrameErr = 1'b0;
    repeat (2) tick();
    check("rst_empty", RxFIFO_Empty, 1);
    check("rst_full", RxFIFO_Full, 0);
    check("rst_rdata", DSP_RDATA, 8'h00);
    check("rst_ovr", RxOverrun, 0);
    check("rst_l2", RxFIFO_L2_Full, 0);
    check("rst_trig", RxTrigger, 0);
    check("rst_err", RxErrInFIFO, 0);
    check("rst_tmo", RxTimeout, 0);
    RESET = 1'b0;
    repeat (2) tick();

    // Fill 0x00..0x0F and check the trigger boundary at 3 and 4 entries.
    RxTrigLvl = 2'b01;
    for (int i = 0; i < 16; i++) begin
      push(8'(i), 1'b0, 1'b0);
      if (i == 2) begin
        check("trig4_at3", RxTrigger, 0);
        check("l2_at3", RxFIFO_L2_Full, 1);
        check("l4_at3", RxFIFO_L4_Full, 0);
      end
      if (i == 3) check("trig4_at4", RxTrigger, 1);
      if (i == 14) check("full_at15", RxFIFO_Full, 0);
    end
    check("fill_full", RxFIFO_Full, 1);
    check("fill_l14", RxFIFO_L14_Full, 1);
    check("fill_l12", RxFIFO_L12_Full, 1);
    check("fill_l8", RxFIFO_L8_Full, 1);
    check("fill_l4", RxFIFO_L4_Full, 1);
    check("fill_l2", RxFIFO_L2_Full, 1);
    for (int l = 0; l < 4; l++) begin
      RxTrigLvl = 2'(l);
      #1;
      check("fill_trig", RxTrigger, 1);
    end
    for (int i = 0; i < 16; i++) begin
      read_byte(d);
      check("in_order", d, 8'(i));
    end
    check("drain_empty", RxFIFO_Empty, 1);

    // Overrun while full, then simultaneous push and pop while full.
    for (int i = 0; i < 16; i++) push(8'(i), 1'b0, 1'b0);
    push(8'hAA, 1'b0, 1'b0);
    check("ovr_set", RxOverrun, 1);
    check("ovr_head", DSP_RDATA, 8'h00);
    pulse_ovr_clr();
    check("ovr_clr", RxOverrun, 0);
    RxDataValid = 1'b1; RxData = 8'hBB; DSP_CEn = 1'b0; DSP_REn = 1'b0;
    tick();
    RxDataValid = 1'b0; DSP_CEn = 1'b1; DSP_REn = 1'b1;
    tick();
    check("pp_full", RxFIFO_Full, 1);
    check("pp_no_ovr", RxOverrun, 0);
    check("pp_head", DSP_RDATA, 8'h01);
    for (int i = 0; i < 16; i++) begin
      read_byte(d);
      check("pp_order", d, (i < 15) ? 8'(i + 1) : 8'hBB);
    end
    check("pp_empty", RxFIFO_Empty, 1);

    // Holding-register mode.
    RxFIFO_En = 1'b0;
    tick();
    push(8'h55, 1'b0, 1'b0);
    check("hold_full", RxFIFO_Full, 1);
    check("hold_head", DSP_RDATA, 8'h55);
    push(8'h66, 1'b0, 1'b0);
    check("hold_ovr", RxOverrun, 1);
    read_byte(d);
    check("hold_read", d, 8'h55);
    check("hold_empty", RxFIFO_Empty, 1);
    pulse_ovr_clr();
    push(8'h77, 1'b0, 1'b0);
    RxFIFO_En = 1'b1;
    tick();
    check("mode_flush", RxFIFO_Empty, 1);
    check("mode_rdata", DSP_RDATA, 8'h00);

    // Long strobe pops once; empty read is ignored.
    push(8'h31, 1'b0, 1'b0);
    push(8'h32, 1'b0, 1'b0);
    push(8'h33, 1'b0, 1'b0);
    DSP_CEn = 1'b0; DSP_REn = 1'b0;
    repeat (5) tick();
    DSP_CEn = 1'b1; DSP_REn = 1'b1;
    tick();
    check("long_strb_head", DSP_RDATA, 8'h32);
    check("long_strb_l2", RxFIFO_L2_Full, 1);
    read_byte(d);
    check("long_strb_r1", d, 8'h32);
    read_byte(d);
    check("long_strb_r2", d, 8'h33);
    check("long_strb_empty", RxFIFO_Empty, 1);
    read_byte(d);
    check("empty_read", d, 8'h00);
    check("empty_read_empty", RxFIFO_Empty, 1);
    push(8'h44, 1'b0, 1'b0);
    check("after_empty_head", DSP_RDATA, 8'h44);
    check("after_empty_l2", RxFIFO_L2_Full, 0);
    read_byte(d);

    // Error tracking.
    push(8'h11, 1'b1, 1'b0);
    push(8'h22, 1'b0, 1'b0);
    check("err_in_fifo", RxErrInFIFO, 1);
    check("err_head_par", RxHeadParityErr, 1);
    check("err_head_frm", RxHeadFrameErr, 0);
    read_byte(d);
    check("err_pop_data", d, 8'h11);
    check("err_cleared", RxErrInFIFO, 0);
    check("err_head_par2", RxHeadParityErr, 0);
    check("err_head_next", DSP_RDATA, 8'h22);
    read_byte(d);
    push(8'h5A, 1'b0, 1'b1);
    check("frm_head", RxHeadFrameErr, 1);
    check("frm_in_fifo", RxErrInFIFO, 1);
    read_byte(d);
    check("frm_cleared", RxErrInFIFO, 0);

    // Timeout fires exactly 20 cycles after the last push.
    push(8'h99, 1'b0, 1'b0);
    repeat (19) tick();
    check("tmo_19", RxTimeout, 0);
    tick();
    check("tmo_20", RxTimeout, 1);
    read_byte(d);
    check("tmo_data", d, 8'h99);
    check("tmo_cleared", RxTimeout, 0);

    // Asynchronous reset in the middle of activity.
    RxFIFO_En = 1'b0;
    tick();
    push(8'hE1, 1'b1, 1'b0);
    push(8'hE2, 1'b0, 1'b0);
    check("pre_rst_ovr", RxOverrun, 1);
    check("pre_rst_err", RxErrInFIFO, 1);
    RxDataValid = 1'b1; RxData = 8'hE3; DSP_CEn = 1'b0; DSP_REn = 1'b0;
    @(posedge DSP_CLK);
    #3;
    RESET = 1'b1;
    #1;
    check("arst_empty", RxFIFO_Empty, 1);
    check("arst_full", RxFIFO_Full, 0);
    check("arst_rdata", DSP_RDATA, 8'h00);
    check("arst_ovr", RxOverrun, 0);
    check("arst_err", RxErrInFIFO, 0);
    check("arst_hpar", RxHeadParityErr, 0);
    check("arst_tmo", RxTimeout, 0);
    RxDataValid = 1'b0; DSP_CEn = 1'b1; DSP_REn = 1'b1;
    tick();
    RESET = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
